// File: rtl/branch_offset_encoder.sv
// Purpose : encode branch target as a signed PC-relative immediate, flag unencodable offsets.
// Latency : 2 cycles from accept to out_valid (stage 1 diff/range, stage 2 output register).
// Backpressure: valid/ready both sides; holds up to 2 results; in_ready drops when both stages are stalled.
// Option  : define BRANCH_OFFSET_ALIGN_CHECK_EN to also reject offsets with diff[1:0] != 0.
module branch_offset_encoder #(
  parameter int PC_W  = 32,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [PC_W-1:0]  in_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IMM_W-1:0] out_imm,
  output logic             out_range_err,
  output logic [7:0]       err_count
);

  // Offset arithmetic on the incoming request
  logic [PC_W-1:0]    diff;
  logic [PC_W-IMM_W:0] diff_upper;
  logic               range_err;
  logic               align_err;
  logic               req_err;

  // Pipeline state
  logic             s1_vld_q, s1_vld_d;
  logic [IMM_W-1:0] s1_diff_q, s1_diff_d;
  logic             s1_err_q, s1_err_d;
  logic             s2_vld_q, s2_vld_d;
  logic [IMM_W-1:0] s2_imm_q, s2_imm_d;
  logic             s2_err_q, s2_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic s2_adv;
  logic s1_load;

  // Offset and error classification: encodable iff the bits above the sign bit replicate it
  always_comb begin
    diff       = in_target - in_pc;
    diff_upper = diff[PC_W-1:IMM_W-1];
    range_err  = !((&diff_upper) || !(|diff_upper));
`ifdef BRANCH_OFFSET_ALIGN_CHECK_EN
    align_err  = |diff[1:0];
`else
    align_err  = 1'b0;
`endif
    req_err    = range_err || align_err;
  end

  // Handshake: stage 2 moves when empty or drained; stage 1 loads when empty or moving on
  always_comb begin
    s2_adv   = !s2_vld_q || out_ready;
    s1_load  = !s1_vld_q || s2_adv;
    in_ready = rst_n && s1_load;
  end

  // Next-state for both pipeline stages and the saturating error counter
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_diff_d = s1_diff_q;
    s1_err_d  = s1_err_q;
    s2_vld_d  = s2_vld_q;
    s2_imm_d  = s2_imm_q;
    s2_err_d  = s2_err_q;
    err_cnt_d = err_cnt_q;

    if (s1_load) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_diff_d = diff[IMM_W-1:0];
        s1_err_d  = req_err;
      end
    end

    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_imm_d = s1_err_q ? '0 : s1_diff_q;
        s2_err_d = s1_err_q;
      end
    end

    if (s2_vld_q && out_ready && s2_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State registers; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_diff_q <= '0;
      s1_err_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_imm_q  <= '0;
      s2_err_q  <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_diff_q <= s1_diff_d;
      s1_err_q  <= s1_err_d;
      s2_vld_q  <= s2_vld_d;
      s2_imm_q  <= s2_imm_d;
      s2_err_q  <= s2_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid     = s2_vld_q;
  assign out_imm       = s2_imm_q;
  assign out_range_err = s2_err_q;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_branch_offset_encoder.sv
// Scoreboard bench for branch_offset_encoder: driver pushes expected results on accept,
// a negedge monitor pops and compares on every output transfer.
module tb_branch_offset_encoder;
  localparam int PC_W  = 32;
  localparam int IMM_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PC_W-1:0]  in_pc = '0;
  logic [PC_W-1:0]  in_target = '0;
  logic             out_valid;
  logic             out_ready;
  logic [IMM_W-1:0] out_imm;
  logic             out_range_err;
  logic [7:0]       err_count;

  logic rnd_mode = 1'b0;
  logic rdy_rnd  = 1'b0;
  logic rdy_man  = 1'b1;
  assign out_ready = rnd_mode ? rdy_rnd : rdy_man;

  branch_offset_encoder #(.PC_W(PC_W), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_range_err(out_range_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [IMM_W-1:0] imm;
    logic             err;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   hold_rdy = 1'b0;
  int   err_model = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  // Reference: signed distance must fit in IMM_W bits; immediate is that distance mod 2^IMM_W
  function automatic exp_t model(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt);
    exp_t        e;
    logic [PC_W-1:0] d;
    longint      sd;
    longint      lim;
    d   = tgt - pc;
    sd  = longint'($signed(d));
    lim = longint'(1) <<< (IMM_W - 1);
    e.err = (sd < -lim) || (sd > lim - 1);
`ifdef BRANCH_OFFSET_ALIGN_CHECK_EN
    if ((sd % 4) != 0) e.err = 1'b1;
`endif
    e.imm = e.err ? '0 : IMM_W'(sd);
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Present one request, wait for acceptance, record expected result at the accept point
  task automatic send_e(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt, input exp_t e_in);
    exp_t e;
    int   w;
    e = e_in;
    w = 0;
    in_valid  = 1'b1;
    in_pc     = pc;
    in_target = tgt;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      fail_now("accept_wait");
    end else begin
      e.acc = cyc;
      e.lat = hold_rdy;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_pc     = $urandom;
    in_target = $urandom;
  endtask

  task automatic send(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt);
    send_e(pc, tgt, model(pc, tgt));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q.size() != 0 || out_valid) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) fail_now("drain");
    @(posedge clk);
    #1;
  endtask

  // Random consumer readiness for the randomized phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy_rnd = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compare transfers, check output stability under stall, track error count
  initial begin
    exp_t             e;
    bit               cnt_pend;
    bit               hold_pend;
    logic [IMM_W-1:0] hold_imm;
    logic             hold_err;
    cnt_pend  = 1'b0;
    hold_pend = 1'b0;
    hold_imm  = '0;
    hold_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        err_model = 0;
        cnt_pend  = 1'b0;
        hold_pend = 1'b0;
      end else begin
        if (cnt_pend) chk("err_count", 32'(err_count), 32'(err_model));
        if (hold_pend) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_imm", 32'(out_imm), 32'(hold_imm));
          chk("hold_err", 32'(out_range_err), 32'(hold_err));
        end
        cnt_pend  = 1'b0;
        hold_pend = 1'b0;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 32'(out_valid), 32'd0);
          end else begin
            e = q.pop_front();
            chk("out_imm", 32'(out_imm), 32'(e.imm));
            chk("out_range_err", 32'(out_range_err), 32'(e.err));
            if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd2);
            if (e.err && err_model < 255) err_model++;
            cnt_pend = 1'b1;
          end
        end else if (out_valid) begin
          hold_pend = 1'b1;
          hold_imm  = out_imm;
          hold_err  = out_range_err;
        end
      end
    end
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [15:0] imm;
    logic        err;
  } dir_t;

  dir_t dir_tab[7] = '{
    '{32'h80000000, 32'h80001234, 16'h1234, 1'b0},
    '{32'h80000004, 32'h80000003, 16'hFFFF, 1'b0},
    '{32'h80000008, 32'h80008007, 16'h7FFF, 1'b0},
    '{32'h80000010, 32'h7FFF8010, 16'h8000, 1'b0},
    '{32'h80000000, 32'h80008000, 16'h0000, 1'b1},
    '{32'h80000000, 32'h7FFF7FFF, 16'h0000, 1'b1},
    '{32'hFFFFFFF0, 32'h00000010, 16'h0020, 1'b0}
  };

  initial begin
    exp_t        e;
    logic [31:0] pc;
    logic [31:0] off;
    int          sel;

    // Reset state
    rst_n   = 1'b0;
    rdy_man = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_imm", 32'(out_imm), 32'd0);
    chk("rst_out_err", 32'(out_range_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed in-range, out-of-range and wrap-around cases, back to back, latency checked
    hold_rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
`ifdef BRANCH_OFFSET_ALIGN_CHECK_EN
      send(dir_tab[i].pc, dir_tab[i].tgt);
`else
      e     = model(dir_tab[i].pc, dir_tab[i].tgt);
      e.imm = dir_tab[i].imm;
      e.err = dir_tab[i].err;
      send_e(dir_tab[i].pc, dir_tab[i].tgt, e);
`endif
    end
    drain();
`ifndef BRANCH_OFFSET_ALIGN_CHECK_EN
    chk("err_count_directed", 32'(err_count), 32'd2);
`else
    e     = model(32'h80000000, 32'h80000006);
    e.imm = 16'h0000;
    e.err = 1'b1;
    send_e(32'h80000000, 32'h80000006, e);
    e     = model(32'h80000000, 32'h80000008);
    e.imm = 16'h0008;
    e.err = 1'b0;
    send_e(32'h80000000, 32'h80000008, e);
    drain();
`endif

    // Randomized traffic with random consumer stalls
    hold_rdy = 1'b0;
    rnd_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      pc  = $urandom;
      sel = $urandom_range(0, 3);
      case (sel)
        0: off = 32'($urandom_range(0, 65535)) - 32'd32768;
        1: begin
          case ($urandom_range(0, 3))
            0: off = 32'hFFFF8000;
            1: off = 32'hFFFF7FFF;
            2: off = 32'h00007FFF;
            default: off = 32'h00008000;
          endcase
        end
        2: off = $urandom;
        default: off = 32'($urandom_range(0, 140000)) - 32'd70000;
      endcase
      send(pc, pc + off);
    end
    rnd_mode = 1'b0;
    rdy_man  = 1'b1;
    drain();

    // Backpressure: two accepts fill the pipe, third waits, all three emerge in order
    rdy_man = 1'b0;
    send(32'h00001000, 32'h00001100);
    send(32'h00002000, 32'h0000A000);
    fork
      send(32'h00003000, 32'h00002FFC);
    join_none
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_imm", 32'(out_imm), 32'h0100);
    end
    @(posedge clk);
    #1;
    rdy_man = 1'b1;
    wait fork;
    drain();

    // Reset with two results in flight
    rdy_man = 1'b0;
    send(32'h80000000, 32'h80008000);
    send(32'h80000000, 32'h80000040);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_out_err", 32'(out_range_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_rel", 32'(in_ready), 32'd1);
    chk("midrst_out_valid_rel", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rdy_man = 1'b1;

    // Saturation: 300 erroneous transfers
    hold_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pc = $urandom;
      send(pc, pc + 32'h00010000 + 32'($urandom_range(0, 4096)));
    end
    drain();
    chk("err_count_sat", 32'(err_count), 32'd255);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
